// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 encodings, byte enables,
// FSM states and access-size helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        IDLE,
        WAIT
    } memState_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } accSize_t;

    // Stores only know SB/SH/SW, so the unsigned load encodings fall back to word.
    function automatic accSize_t accessSize(input logic [2:0] funct3, input logic isStore);
        accSize_t size;
        case (funct3)
            F3_B:    size = SZ_BYTE;
            F3_H:    size = SZ_HALF;
            F3_BU:   size = isStore ? SZ_WORD : SZ_BYTE;
            F3_HU:   size = isStore ? SZ_WORD : SZ_HALF;
            default: size = SZ_WORD;
        endcase
        return size;
    endfunction

    function automatic logic [3:0] storeByteEnable(input accSize_t size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_BYTE << off;
            SZ_HALF: be = BE_HALF << {off[1], 1'b0};
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic isMisaligned(input accSize_t size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Halves only look at off[1]; the low address bit is ignored for them.
    always_comb begin
        byteSel = rdata[{off, 3'b000} +: 8];
        halfSel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byteSel[7]}}, byteSel};
            F3_BU:   data = {24'b0, byteSel};
            F3_H:    data = {{16{halfSel[15]}}, halfSel};
            F3_HU:   data = {16'b0, halfSel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: data-memory handshake, store lane steering, load alignment
// and the MEM/WB register. Define MEMCYCLE_MISALIGN_TRAP_EN to trap misaligned accesses.
module memory_cycle
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [2:0]        Funct3M,
    input  logic [31:0]       PCPlus4M,
    input  logic [31:0]       ALU_ResultM,
    input  logic [31:0]       WriteDataM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RDW,
    output logic [31:0]       PCPlus4W,
    output logic [31:0]       ALU_ResultW,
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
    output logic              misaligned_excW,
`endif
    output logic [31:0]       ReadDataW
);

    memState_t   state;
    memState_t   stateNext;

    logic        acc;
    logic        misaligned;
    logic        issue;
    accSize_t    liveSize;
    logic [1:0]  liveOff;
    logic [3:0]  liveBe;
    logic [31:0] liveWdata;

    logic        reqWe;
    logic [31:0] reqAddr;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;
    logic [2:0]  reqFunct3;

    logic [31:0] curAddr;
    logic [2:0]  curFunct3;
    logic [31:0] loadData;

    assign acc = MemWriteM | ResultSrcM;

    // Bus fields as they would be issued straight from the M-stage inputs.
    always_comb begin
        liveSize = accessSize(Funct3M, MemWriteM);
        liveOff  = ALU_ResultM[1:0];
        liveBe   = MemWriteM ? storeByteEnable(liveSize, liveOff) : BE_WORD;
        case (liveSize)
            SZ_BYTE: liveWdata = {4{WriteDataM[7:0]}};
            SZ_HALF: liveWdata = {2{WriteDataM[15:0]}};
            default: liveWdata = WriteDataM;
        endcase
    end

`ifdef MEMCYCLE_MISALIGN_TRAP_EN
    assign misaligned = acc & isMisaligned(liveSize, liveOff);
`else
    assign misaligned = 1'b0;
`endif

    assign issue = acc & ~misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // While waiting, the bus is driven from the copy taken at request rise so it
    // cannot move before the memory answers.
    always_comb begin
        stateNext  = state;
        dmem_req   = 1'b0;
        dmem_we    = MemWriteM;
        curAddr    = ALU_ResultM;
        curFunct3  = Funct3M;
        dmem_be    = liveBe;
        dmem_wdata = liveWdata;
        StallM     = 1'b0;
        case (state)
            IDLE: begin
                dmem_req = issue;
                if (issue && !dmem_ready) begin
                    StallM    = 1'b1;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = reqWe;
                curAddr    = reqAddr;
                curFunct3  = reqFunct3;
                dmem_be    = reqBe;
                dmem_wdata = reqWdata;
                StallM     = ~dmem_ready;
                if (dmem_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign dmem_addr = ADDR_W'({curAddr[31:2], 2'b00});

    always_ff @(posedge clk) begin
        if (state == IDLE && issue && !dmem_ready) begin
            reqWe     <= MemWriteM;
            reqAddr   <= ALU_ResultM;
            reqBe     <= liveBe;
            reqWdata  <= liveWdata;
            reqFunct3 <= Funct3M;
        end
    end

    load_align u_loadAlign (
        .rdata  (dmem_rdata),
        .off    (curAddr[1:0]),
        .funct3 (curFunct3),
        .data   (loadData)
    );

    // A stalled edge pushes a bubble into writeback; the remaining fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW       <= 1'b0;
            ResultSrcW      <= 1'b0;
            RDW             <= 5'd0;
            PCPlus4W        <= 32'd0;
            ALU_ResultW     <= 32'd0;
            ReadDataW       <= 32'd0;
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
            misaligned_excW <= 1'b0;
`endif
        end else if (StallM) begin
            RegWriteW       <= 1'b0;
            ResultSrcW      <= 1'b0;
            RDW             <= 5'd0;
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
            misaligned_excW <= 1'b0;
`endif
        end else begin
            RegWriteW       <= RegWriteM & ~misaligned;
            ResultSrcW      <= ResultSrcM;
            RDW             <= RD_M;
            PCPlus4W        <= PCPlus4M;
            ALU_ResultW     <= ALU_ResultM;
            ReadDataW       <= loadData;
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
            misaligned_excW <= misaligned;
`endif
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle: the bench plays the data memory with a
// programmable ready delay and predicts every bus and writeback value arithmetically.
module tb_memory_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [2:0]  Funct3M;
    logic [31:0] PCPlus4M;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RDW;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
    logic        misaligned_excW;
`endif

    int checkCount = 0;
    int passCount  = 0;

    memory_cycle #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .Funct3M     (Funct3M),
        .PCPlus4M    (PCPlus4M),
        .ALU_ResultM (ALU_ResultM),
        .WriteDataM  (WriteDataM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RDW         (RDW),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
        .misaligned_excW (misaligned_excW),
`endif
        .ReadDataW   (ReadDataW)
    );

    always #5 clk = ~clk;

    // One M-stage instruction; the memory answers after 'waits' stalled cycles.
    task automatic applyStimulus(input string name, input logic rw, input logic mw, input logic rs,
                                 input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int waits);
        logic        acc;
        logic        isByte;
        logic        isHalf;
        logic        mis;
        logic        expReq;
        logic [1:0]  off;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [31:0] expLoad;
        int          effWaits;

        acc    = mw | rs;
        off    = alu[1:0];
        isByte = (f3 == 3'd0) || (!mw && f3 == 3'd4);
        isHalf = (f3 == 3'd1) || (!mw && f3 == 3'd5);
        mis    = 1'b0;
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
        mis    = acc && ((isHalf && off[0]) || (!isByte && !isHalf && off != 2'd0));
`endif
        expReq   = acc && !mis;
        effWaits = expReq ? waits : 0;
        expAddr  = alu & 32'hFFFF_FFFC;

        if (!mw)         expBe = 4'hF;
        else if (isByte) expBe = 4'b0001 << off;
        else if (isHalf) expBe = alu[1] ? 4'hC : 4'h3;
        else             expBe = 4'hF;

        if (isByte)      expWdata = 32'(wd[7:0]) * 32'h0101_0101;
        else if (isHalf) expWdata = 32'(wd[15:0]) * 32'h0001_0001;
        else             expWdata = wd;

        if (isByte) begin
            expLoad = (rdata >> (8 * 32'(off))) & 32'hFF;
            if (f3 == 3'd0 && expLoad[7]) expLoad = expLoad - 32'h100;
        end else if (isHalf) begin
            expLoad = (rdata >> (16 * 32'(alu[1]))) & 32'hFFFF;
            if (f3 == 3'd1 && expLoad[15]) expLoad = expLoad - 32'h1_0000;
        end else begin
            expLoad = rdata;
        end

        @(negedge clk);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        RD_M        = rd;
        Funct3M     = f3;
        PCPlus4M    = pc;
        ALU_ResultM = alu;
        WriteDataM  = wd;
        dmem_rdata  = rdata;
        for (int c = 0; c <= effWaits; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ready = expReq ? (c == effWaits) : 1'($urandom_range(0, 1));
            #1;
            checkCount++;
            if ({dmem_req, StallM} !== {expReq, (c < effWaits)}) begin
                $display("[TB] FAIL %s req/stall cyc%0d: got %b expected %b", name, c,
                         {dmem_req, StallM}, {expReq, (c < effWaits)});
            end else passCount++;
            if (expReq) begin
                checkCount++;
                if ({dmem_we, dmem_addr, dmem_be} !== {mw, expAddr, expBe}) begin
                    $display("[TB] FAIL %s bus cyc%0d: got we/addr/be %h expected %h", name, c,
                             {dmem_we, dmem_addr, dmem_be}, {mw, expAddr, expBe});
                end else passCount++;
                if (mw) begin
                    checkCount++;
                    if (dmem_wdata !== expWdata) begin
                        $display("[TB] FAIL %s wdata cyc%0d: got %h expected %h", name, c,
                                 dmem_wdata, expWdata);
                    end else passCount++;
                end
            end
            @(posedge clk);
            #1;
            if (c < effWaits) begin
                checkCount++;
                if ({RegWriteW, ResultSrcW, RDW} !== 7'd0) begin
                    $display("[TB] FAIL %s bubble cyc%0d: got %h expected 00", name, c,
                             {RegWriteW, ResultSrcW, RDW});
                end else passCount++;
            end else begin
                checkCount++;
                if ({RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW} !==
                    {rw & ~mis, rs, rd, pc, alu}) begin
                    $display("[TB] FAIL %s capture: got %h expected %h", name,
                             {RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW},
                             {rw & ~mis, rs, rd, pc, alu});
                end else passCount++;
                if (rs && !mis) begin
                    checkCount++;
                    if (ReadDataW !== expLoad) begin
                        $display("[TB] FAIL %s ReadDataW: got %h expected %h", name,
                                 ReadDataW, expLoad);
                    end else passCount++;
                end
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
                checkCount++;
                if (misaligned_excW !== mis) begin
                    $display("[TB] FAIL %s misaligned_excW: got %b expected %b", name,
                             misaligned_excW, mis);
                end else passCount++;
`endif
            end
        end
    endtask

    task automatic clearInputs();
        RegWriteM   = 1'b0;
        MemWriteM   = 1'b0;
        ResultSrcM  = 1'b0;
        RD_M        = 5'd0;
        Funct3M     = 3'd0;
        PCPlus4M    = 32'd0;
        ALU_ResultM = 32'd0;
        WriteDataM  = 32'd0;
        dmem_ready  = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW} !== 103'd0) begin
            $display("[TB] FAIL reset W outputs: got %h expected 0",
                     {RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW});
        end else passCount++;
        checkCount++;
        if ({dmem_req, StallM} !== 2'b00) begin
            $display("[TB] FAIL reset req/stall: got %b expected 00", {dmem_req, StallM});
        end else passCount++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        applyStimulus("alu", 1'b1, 1'b0, 1'b0, 5'd5, 3'd0, 32'h0000_0104, 32'h0000_1234,
                      32'hCAFE_0000, 32'h0, 0);
    endtask

    task automatic test_load_byte();
        applyStimulus("lb", 1'b1, 1'b0, 1'b1, 5'd7, 3'd0, 32'h0000_0108, 32'h0000_0103,
                      32'h0, 32'h80FF_FF7F, 0);
        applyStimulus("lbu", 1'b1, 1'b0, 1'b1, 5'd8, 3'd4, 32'h0000_010C, 32'h0000_0103,
                      32'h0, 32'h80FF_FF7F, 0);
    endtask

    task automatic test_store_half();
        applyStimulus("sh", 1'b0, 1'b1, 1'b0, 5'd0, 3'd1, 32'h0000_0110, 32'h0000_0202,
                      32'hDEAD_BEEF, 32'h0, 0);
    endtask

    task automatic test_load_wait();
        applyStimulus("lw_wait3", 1'b1, 1'b0, 1'b1, 5'd10, 3'd2, 32'h0000_0114, 32'h0000_0400,
                      32'h0, 32'h1357_9BDF, 3);
    endtask

    task automatic test_reset_in_wait();
        applyStimulus("pre_rst_alu", 1'b1, 1'b0, 1'b0, 5'd9, 3'd0, 32'h0000_0044, 32'h0000_0088,
                      32'h0, 32'h0, 0);
        @(negedge clk);
        RegWriteM   = 1'b1;
        ResultSrcM  = 1'b1;
        MemWriteM   = 1'b0;
        RD_M        = 5'd3;
        Funct3M     = 3'd2;
        ALU_ResultM = 32'h0000_0300;
        dmem_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkCount++;
        if ({dmem_req, StallM} !== 2'b11) begin
            $display("[TB] FAIL rst_wait pending: got %b expected 11", {dmem_req, StallM});
        end else passCount++;
        rst = 1'b1;
        clearInputs();
        @(posedge clk);
        #1;
        checkCount++;
        if ({dmem_req, StallM} !== 2'b00) begin
            $display("[TB] FAIL rst_wait req/stall: got %b expected 00", {dmem_req, StallM});
        end else passCount++;
        checkCount++;
        if ({RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW} !== 103'd0) begin
            $display("[TB] FAIL rst_wait W outputs: got %h expected 0",
                     {RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW});
        end else passCount++;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef MEMCYCLE_MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        applyStimulus("lw_mis", 1'b1, 1'b0, 1'b1, 5'd12, 3'd2, 32'h0000_0200, 32'h0000_0101,
                      32'h0, 32'hAAAA_5555, 2);
        applyStimulus("after_mis", 1'b1, 1'b0, 1'b0, 5'd13, 3'd0, 32'h0000_0204, 32'h0000_0777,
                      32'h0, 32'h0, 0);
    endtask
`endif

    task automatic test_back_to_back();
        applyStimulus("b2b_lw", 1'b1, 1'b0, 1'b1, 5'd1, 3'd2, 32'h0000_0500, 32'h0000_1000,
                      32'h0, 32'hFEDC_BA98, 0);
        applyStimulus("b2b_sw", 1'b0, 1'b1, 1'b0, 5'd0, 3'd2, 32'h0000_0504, 32'h0000_1004,
                      32'h0BAD_F00D, 32'h0, 0);
        applyStimulus("b2b_lh", 1'b1, 1'b0, 1'b1, 5'd2, 3'd1, 32'h0000_0508, 32'h0000_1006,
                      32'h0, 32'h8001_7FFE, 1);
        applyStimulus("b2b_sb", 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0000_050C, 32'h0000_1001,
                      32'h0000_00A5, 32'h0, 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] alu;
            kind = int'($urandom_range(0, 2));
            alu  = $urandom;
            applyStimulus("rand", 1'($urandom_range(0, 1)), (kind == 2), (kind == 1),
                          5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom, alu,
                          $urandom, $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        clearInputs();
        test_reset();
        test_alu_op();
        test_load_byte();
        test_store_half();
        test_load_wait();
        test_reset_in_wait();
`ifdef MEMCYCLE_MISALIGN_TRAP_EN
        test_misalign_trap();
`endif
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
